// File: rtl/mux_arb_nxw_pkg.sv
// mux_arb_nxw_pkg: shared arbitration-mode encodings and select-width helper
package mux_arb_nxw_pkg;
  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_ROUND = 1'b1;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_arb_nxw_rr_arbiter.sv
// rr_arbiter_n: round-robin / fixed-priority grant with explicit non-power-of-2 pointer wrap
module rr_arbiter_n
  import mux_arb_nxw_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int SEL_W  = sel_w(NUM_IN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  input  logic              mode,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);
  logic [SEL_W-1:0] rr_ptr;
  logic found;
  int idx;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    idx = 0;
    for (int j = 0; j < NUM_IN; j++) begin
      idx = (mode == ARB_ROUND) ? int'(rr_ptr) + j : j;
      idx = (idx >= NUM_IN) ? idx - NUM_IN : idx;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = SEL_W'(idx);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else if (advance && mode == ARB_ROUND)
      rr_ptr <= (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
  end
endmodule

// File: rtl/mux_arb_nxw.sv
// mux_arb_nxw: arbitrated N-input mux with valid/ready handshake and one registered output stage
module mux_arb_nxw
  import mux_arb_nxw_pkg::*;
#(
  parameter int   NUM_IN  = 8,
  parameter int   WIDTH   = 8,
  parameter logic RR_MODE = ARB_ROUND,
  parameter int   SEL_W   = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);
  logic load, fire;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;
  assign load = !out_valid || out_ready;
  assign in_ready = (load && !reset) ? grant : '0;
  assign fire = |(in_ready & in_valid);
  rr_arbiter_n #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (fire),
    .mode      (RR_MODE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );
  // grant is one-hot, so an OR of gated channels is the select
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++)
      sel_data = sel_data | (grant[i] ? in_data[i*WIDTH +: WIDTH] : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
    end else if (load) begin
      out_valid <= fire;
      if (fire) begin
        out_data <= sel_data;
        out_sel <= grant_idx;
      end
    end
  end
endmodule

// File: tb/tb_mux_arb_nxw.sv
// tb_mux_arb_nxw: scoreboard bench over three configurations (8 RR, 5 RR, 8 fixed priority)
module tb_mux_arb_nxw;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0] in_valid = '0;
  logic out_ready = 1'b1;
  logic [7:0] ir_a, ir_c, od_a, od_b, od_c;
  logic [4:0] ir_b;
  logic [2:0] os_a, os_b, os_c;
  logic ov_a, ov_b, ov_c;
  int checks = 0;
  int fails = 0;
  int n_of [3] = '{8, 5, 8};
  bit rr_of [3] = '{1'b1, 1'b1, 1'b0};
  int ptr [3];
  bit occ [3];
  logic [10:0] qbuf [3][16];
  int wp [3];
  int rp [3];

  always #5 clk = ~clk;

  mux_arb_nxw #(.NUM_IN(8), .WIDTH(8), .RR_MODE(1'b1)) dut_a (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_a),
    .out_data(od_a), .out_sel(os_a), .out_valid(ov_a), .out_ready(out_ready));
  mux_arb_nxw #(.NUM_IN(5), .WIDTH(8), .RR_MODE(1'b1)) dut_b (
    .clk(clk), .reset(rst), .in_data(in_data[39:0]), .in_valid(in_valid[4:0]), .in_ready(ir_b),
    .out_data(od_b), .out_sel(os_b), .out_valid(ov_b), .out_ready(out_ready));
  mux_arb_nxw #(.NUM_IN(8), .WIDTH(8), .RR_MODE(1'b0)) dut_c (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_c),
    .out_data(od_c), .out_sel(os_c), .out_valid(ov_c), .out_ready(out_ready));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int k);
    for (int j = 0; j < n_of[k]; j++) begin
      int idx;
      idx = rr_of[k] ? (ptr[k] + j) % n_of[k] : j;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // monitor + reference model: compare state left by the last edge, then predict the next edge
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [7:0] ir, od;
      logic [2:0] os;
      logic ov, ld;
      logic [10:0] e;
      int g;
      ir = (k == 0) ? ir_a : (k == 1) ? {3'b000, ir_b} : ir_c;
      od = (k == 0) ? od_a : (k == 1) ? od_b : od_c;
      os = (k == 0) ? os_a : (k == 1) ? os_b : os_c;
      ov = (k == 0) ? ov_a : (k == 1) ? ov_b : ov_c;
      if (rst) begin
        check($sformatf("in_ready_in_reset[%0d]", k), 32'(ir), 32'd0);
        occ[k] = 1'b0;
        ptr[k] = 0;
        rp[k] = wp[k];
      end else begin
        ld = !occ[k] || out_ready;
        g = ld ? pick(k) : -1;
        check($sformatf("in_ready[%0d]", k), 32'(ir), (g >= 0) ? (32'd1 << g) : 32'd0);
        check($sformatf("out_valid[%0d]", k), 32'(ov), 32'(occ[k]));
        if (occ[k] && out_ready && rp[k] != wp[k]) begin
          e = qbuf[k][rp[k] % 16];
          rp[k]++;
          check($sformatf("out_data[%0d]", k), 32'(od), 32'(e[7:0]));
          check($sformatf("out_sel[%0d]", k), 32'(os), 32'(e[10:8]));
        end
        if (ld) begin
          occ[k] = (g >= 0);
          if (g >= 0) begin
            qbuf[k][wp[k] % 16] = {3'(g), in_data[g*8 +: 8]};
            wp[k]++;
            if (rr_of[k]) ptr[k] = (g + 1) % n_of[k];
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = {4'(i), 4'(i)};
    in_valid = 8'hFF;
    step(20);
    in_valid = 8'h44;
    step(8);
    in_valid = 8'h04;
    step(4);
    in_valid = 8'h2A;
    step(6);
    in_valid = 8'h28;
    step(4);
    in_valid = 8'hFF;
    out_ready = 1'b0;
    step(6);
    out_ready = 1'b1;
    step(4);
    repeat (300) begin
      in_data = {$urandom, $urandom};
      in_valid = 8'($urandom);
      out_ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(40) == 0);
      step(1);
    end
    rst = 1'b0;
    in_data[31:24] = 8'h33;
    in_valid = 8'h08;
    out_ready = 1'b1;
    step(1);
    in_valid = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    check("held_data_before_reset", 32'(od_a), 32'h33);
    check("held_sel_before_reset", 32'(os_a), 32'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("out_valid_after_reset", 32'(ov_a), 32'd0);
    check("out_data_after_reset", 32'(od_a), 32'd0);
    check("out_sel_after_reset", 32'(os_a), 32'd0);
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
